// File: rtl/sat_sub_accumulator.sv
// Frame accumulator: adds/subtracts NUM_TERMS signed terms with per-step saturation,
// then presents the result until handshaken. Define SAT_SUB_ACC_SAT_FLAG_EN for a sticky out_sat.
module sat_sub_accumulator #(
    parameter int WIDTH     = 32,
    parameter int NUM_TERMS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_TERMS - 1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] step_val;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   ext_acc, ext_in, sum;
    logic             ovf;
    logic             accept, take, last;

    // One extra sign bit makes overflow visible as a disagreement of the top two bits.
    always_comb begin
        ext_acc  = {acc[WIDTH-1], acc};
        ext_in   = {in_data[WIDTH-1], in_data};
        sum      = in_sub ? (ext_acc - ext_in) : (ext_acc + ext_in);
        ovf      = sum[WIDTH] ^ sum[WIDTH-1];
        step_val = sum[WIDTH-1:0];
        if (ovf)
            step_val = sum[WIDTH] ? MAX_NEG : MAX_POS;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;
    assign last   = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else if (accept) begin
            acc <= step_val;
            cnt <= last ? '0 : cnt + CNT_W'(1);
            if (last)
                out_data <= step_val;
        end else if (take) begin
            acc <= '0;
        end
    end

`ifdef SAT_SUB_ACC_SAT_FLAG_EN
    // Sticky across the frame; frozen in DONE because no term is accepted there.
    logic sat_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_flag <= 1'b0;
        else if (accept)
            sat_flag <= sat_flag | ovf;
        else if (take)
            sat_flag <= 1'b0;
    end

    assign out_sat = sat_flag;
`else
    assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_sat_sub_accumulator.sv
// Directed-vector bench for sat_sub_accumulator at WIDTH=8, NUM_TERMS=4.
module tb_sat_sub_accumulator;

`ifdef SAT_SUB_ACC_SAT_FLAG_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_sat;

    int n_vec  = 0;
    int n_miss = 0;

    sat_sub_accumulator #(.WIDTH(8), .NUM_TERMS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one term at the negedge; it is taken on the following posedge.
    task automatic put(input logic s, input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_sub   = s;
        in_data  = d;
        chk("in_ready_accum", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_after_hs", {31'b0, out_valid}, 32'd0);
        chk("ready_after_hs", {31'b0, in_ready}, 32'd1);
    endtask

    // subs[i] selects subtract for term i.
    task automatic run_frame(input string tag, input logic [3:0] subs,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3,
                             input logic [7:0] exp_data, input logic exp_sat,
                             input logic do_hs);
        put(subs[0], d0);
        put(subs[1], d1);
        put(subs[2], d2);
        chk({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
        put(subs[3], d3);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_data"},  {24'b0, out_data}, {24'b0, exp_data});
        chk({tag, "_sat"},   {31'b0, out_sat},  {31'b0, exp_sat & SAT_EN});
        if (do_hs)
            handshake();
    endtask

    initial begin
        #3;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data",  {24'b0, out_data},  32'd0);
        chk("rst_sat",   {31'b0, out_sat},   32'd0);
        chk("rst_ready", {31'b0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 10 + 20 - 5 + (-3) = 22, then stall in DONE with in_valid high
        run_frame("f_basic", 4'b0100, 8'd10, 8'd20, 8'd5, 8'hFD, 8'h16, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sub   = 1'b0;
            in_data  = 8'd50;
            @(posedge clk);
            #1;
            chk("hold_ready", {31'b0, in_ready},  32'd0);
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_data",  {24'b0, out_data},  32'h16);
            chk("hold_sat",   {31'b0, out_sat},   32'd0);
        end
        in_valid = 1'b0;
        handshake();
        run_frame("f_again", 4'b0100, 8'd10, 8'd20, 8'd5, 8'hFD, 8'h16, 1'b0, 1'b1);

        // 100 + 100 clips to 127, -27 -> 100
        run_frame("f_clip_mid", 4'b0100, 8'd100, 8'd100, 8'd27, 8'd0, 8'h64, 1'b1, 1'b1);
        // 0 - (-128) saturates to +127
        run_frame("f_sub_min", 4'b0010, 8'd0, 8'h80, 8'd0, 8'd0, 8'h7F, 1'b1, 1'b1);
        // -100 - 100 saturates to -128
        run_frame("f_neg_sat", 4'b0011, 8'd100, 8'd100, 8'd0, 8'd0, 8'h80, 1'b1, 1'b1);
        // 127 - 127 + (-128) - 0 = -128 exactly, never overflows
        run_frame("f_edge_ok", 4'b1010, 8'd127, 8'd127, 8'h80, 8'd0, 8'h80, 1'b0, 1'b1);
        // 127 + 1 clips, -127 -> 0, + (-128) -> -128
        run_frame("f_max_inc", 4'b0100, 8'd127, 8'd1, 8'd127, 8'h80, 8'h80, 1'b1, 1'b1);

        // Two terms, then an asynchronous reset mid-cycle
        put(1'b0, 8'd100);
        put(1'b0, 8'd100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data",  {24'b0, out_data},  32'd0);
        chk("mid_rst_sat",   {31'b0, out_sat},   32'd0);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("f_post_rst", 4'b0100, 8'd10, 8'd20, 8'd5, 8'hFD, 8'h16, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sat_sub_accumulator.md
SAT_SUB_ACCUMULATOR -- requirements
Module: sat_sub_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: signed operand and result width in bits (minimum 4).
REQ-002 SHALL have parameter NUM_TERMS, default 16: terms per frame (minimum 1).
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: in_data and in_sub are valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a term this cycle.
REQ-007 SHALL have port in_data, input, WIDTH: signed two's-complement term.
REQ-008 SHALL have port in_sub, input, 1: 1 = subtract term, 0 = add term.
REQ-009 SHALL have port out_valid, output, 1: frame result available.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port out_data, output, WIDTH: signed frame result.
REQ-012 SHALL have port out_sat, output, 1: saturation occurred at any step of the frame.

Function
REQ-013 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-014 SHALL accept a term only on in_valid && in_ready; no accept = accumulator, counter and flag unchanged.
REQ-015 Per accepted term, SHALL compute next = acc +/- in_data in WIDTH+1-bit sign-extended arithmetic.
REQ-016 SHALL detect overflow when bit WIDTH differs from bit WIDTH-1 of the WIDTH+1-bit result.
REQ-017 On overflow, SHALL load acc with the max positive value (0 followed by all ones) if bit WIDTH = 0, else the max negative value (1 followed by all zeros); otherwise acc = low WIDTH bits.
REQ-018 Subtracting the max negative value from a non-negative acc SHALL saturate to the max positive value.
REQ-019 Saturation SHALL be applied at every step, not only at frame end.
REQ-020 SHALL count accepted terms 0..NUM_TERMS-1; the accept at count NUM_TERMS-1 moves to DONE on the same edge, count wraps to 0.
REQ-021 out_data SHALL equal the saturated result of the final term, registered, with out_valid=1 on the cycle after the final accept (latency 1).
REQ-022 In DONE, out_data and out_sat SHALL hold stable until out_valid && out_ready.
REQ-023 On the output handshake, SHALL clear acc to 0 and the sat flag to 0, and return to ACCUM on the same edge; in_ready=1 the following cycle.
REQ-024 in_valid asserted in DONE SHALL be ignored (no accept, no state change).
REQ-025 SHALL accept back-to-back terms at one per cycle with no bubbles inside a frame.

Reset
REQ-026 rst_n low SHALL asynchronously force state=ACCUM, acc=0, count=0, sat flag=0, out_valid=0, out_data=0, out_sat=0.
REQ-027 Reset mid-frame or in DONE SHALL discard partial or pending results; first edge after deassertion behaves as a fresh frame.

Configuration
REQ-028 Macro SAT_SUB_ACC_SAT_FLAG_EN defined: out_sat is the sticky OR of per-step overflow across the frame.
REQ-029 Macro SAT_SUB_ACC_SAT_FLAG_EN undefined: no flag register is built, out_sat is tied to 0, and saturation arithmetic is unchanged.

Verification (WIDTH=8, NUM_TERMS=4, macro defined unless stated)
REQ-030 SHALL cover frame add 10, add 20, sub 5, add -3 -> out_data=22, out_sat=0, out_valid one cycle after the 4th accept.
REQ-031 SHALL cover add 100, add 100, sub 27, add 0 -> out_data=100, out_sat=1, because the intermediate value clips to 127.
REQ-032 SHALL cover add 0, sub -128, add 0, add 0 -> out_data=127, out_sat=1; and sub 100, sub 100, add 0, add 0 -> out_data=-128, out_sat=1.
REQ-033 SHALL cover out_ready held low 5 cycles in DONE with in_valid=1 -> out_data stable, in_ready=0, no term consumed; then a handshake -> next frame starts from acc=0.
REQ-034 SHALL cover rst_n pulsed low after 2 accepted terms -> all outputs 0 immediately, and the following 4 terms form a clean frame.
REQ-035 SHALL cover a rerun of REQ-031 with the macro undefined -> out_data=100, out_sat=0.
